// File: rtl/lsu_byte_seq_if.sv
// rtl/lsu_byte_seq_if.sv - core request/response and byte-memory port bundle for lsu_byte_seq
//
// Purpose: groups the core-side load/store handshake and the byte-wide memory
// port into one interface.
// Modports:
//   slave  - the sequencer: takes req_*, mem_rdata; drives req_ready, resp_*, mem_addr/wen/wdata
//   master - the environment (core + memory): the opposite directions
interface lsu_byte_seq_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_wen;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wen, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wen, mem_wdata
  );
endinterface

// File: rtl/lsu_byte_seq.sv
// rtl/lsu_byte_seq.sv - RV32I load/store sequencer over a byte-wide memory
//
// Purpose: accepts one load/store per handshake, issues 1/2/4 single-byte
// accesses at consecutive (wrapping) addresses, and returns an extended load
// result or a store completion, flagging illegal requests with resp_err.
// Ports:
//   clk   - clock, all state changes on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - lsu_byte_seq_if.slave: req_*/resp_* core handshake, mem_* byte port
// Configuration macro: LSU_MISALIGN_TRAP_EN - when defined, misaligned
// halfword/word requests are rejected with an error response.
module lsu_byte_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_byte_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                state, state_next;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0] result_ext;
  logic [1:0]            k;
  logic [1:0]            last_k;
  logic                  err_q;
  logic                  req_legal;

  // Legality is judged on the live request inputs, since it decides the
  // transition out of IDLE in the same cycle the request is accepted.
  always_comb begin
    req_legal = 1'b0;
    if (bus.req_we) begin
      req_legal = (bus.req_funct3[2] == 1'b0) && (bus.req_funct3[1:0] != 2'b11);
    end else begin
      case (bus.req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
        default:                                req_legal = 1'b0;
      endcase
    end
`ifdef LSU_MISALIGN_TRAP_EN
    if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
      req_legal = 1'b0;
    if ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00))
      req_legal = 1'b0;
`endif
  end

  // Index of the final byte: N-1 for N = 1, 2, 4.
  always_comb begin
    case (f3_q[1:0])
      2'b00:   last_k = 2'd0;
      2'b01:   last_k = 2'd1;
      default: last_k = 2'd3;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid) state_next = req_legal ? ACCESS : RESP;
      ACCESS:  if (k == last_k)   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      f3_q     <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      k        <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            f3_q     <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            result_q <= '0;
            k        <= 2'd0;
            err_q    <= ~req_legal;
          end
        end
        ACCESS: begin
          k <= k + 2'd1;
          if (!we_q) result_q[{k, 3'b000} +: 8] <= bus.mem_rdata;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (f3_q)
      3'b000:  result_ext = {{(DATA_WIDTH-8){result_q[7]}}, result_q[7:0]};
      3'b001:  result_ext = {{(DATA_WIDTH-16){result_q[15]}}, result_q[15:0]};
      3'b100:  result_ext = {{(DATA_WIDTH-8){1'b0}}, result_q[7:0]};
      3'b101:  result_ext = {{(DATA_WIDTH-16){1'b0}}, result_q[15:0]};
      default: result_ext = result_q;
    endcase
  end

  // Outputs decode from state only, so an asynchronous reset drops them at once.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    bus.mem_addr   = '0;
    bus.mem_wen    = 1'b0;
    bus.mem_wdata  = 8'h00;
    case (state)
      ACCESS: begin
        bus.mem_addr = addr_q + ADDR_WIDTH'(k);
        if (we_q) begin
          bus.mem_wen   = 1'b1;
          bus.mem_wdata = wdata_q[{k, 3'b000} +: 8];
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = err_q;
        if (!err_q && !we_q) bus.resp_rdata = result_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_byte_seq.sv
// tb/tb_lsu_byte_seq.sv - directed self-checking bench for lsu_byte_seq
module tb_lsu_byte_seq;

  logic clk;
  logic rst_n;

  lsu_byte_seq_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  lsu_byte_seq #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: 512 locations indexed by {addr[16], addr[7:0]}, which keeps
  // 0x0001xxxx, 0x00000000 and 0xFFFFFFFF apart for the addresses used here.
  logic [7:0] mem     [512];
  bit         written [512];
  logic [31:0] wlog_a [$];
  logic [7:0]  wlog_d [$];

  function automatic logic [8:0] idx(input logic [31:0] a);
    return {a[16], a[7:0]};
  endfunction

  function automatic logic [7:0] init_byte(input logic [8:0] i);
    case (i)
      9'h100: return 8'h78;
      9'h101: return 8'h56;
      9'h102: return 8'h34;
      9'h103: return 8'h12;
      9'h104: return 8'h9A;
      9'h110: return 8'h80;
      9'h111: return 8'hFF;
      9'h1FF: return 8'h11;
      9'h000: return 8'h22;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] rd(input logic [31:0] a);
    return written[idx(a)] ? mem[idx(a)] : init_byte(idx(a));
  endfunction

  assign bus.mem_rdata = rd(bus.mem_addr);

  always @(posedge clk) begin
    if (bus.mem_wen) begin
      mem[idx(bus.mem_addr)]     <= bus.mem_wdata;
      written[idx(bus.mem_addr)] <= 1'b1;
      wlog_a.push_back(bus.mem_addr);
      wlog_d.push_back(bus.mem_wdata);
    end
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] addr_log [$];
  int          r_cyc;
  logic        got_resp;
  logic [31:0] r_rdata;
  logic        r_err;
  logic        r_ready;

  // Present one request, then sample every cycle (at negedge) until resp_valid.
  // r_cyc counts cycles after the accept edge, so a legal N-byte op gives N+1.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'hDEADDEAD;
    addr_log.delete();
    r_cyc    = 0;
    got_resp = 1'b0;
    r_rdata  = 32'h0;
    r_err    = 1'b0;
    r_ready  = 1'b0;
    for (int i = 0; i < 20 && !got_resp; i++) begin
      r_cyc++;
      if (bus.resp_valid) begin
        got_resp = 1'b1;
        r_rdata  = bus.resp_rdata;
        r_err    = bus.resp_err;
        r_ready  = bus.req_ready;
      end else begin
        addr_log.push_back(bus.mem_addr);
        @(negedge clk);
      end
    end
    chk("resp_seen", {31'b0, got_resp}, 32'd1);
  endtask

  int wbase;

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("rst_resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata,          32'd0);
    chk("rst_resp_err",   {31'b0, bus.resp_err},   32'd0);
    chk("rst_mem_wen",    {31'b0, bus.mem_wen},    32'd0);
    chk("rst_mem_addr",   bus.mem_addr,            32'd0);
    chk("rst_mem_wdata",  {24'b0, bus.mem_wdata},  32'd0);
    rst_n = 1'b1;

    // lw aligned
    do_req(1'b0, 3'b010, 32'h0001_0000, 32'h0);
    chk("lw_cycles", r_cyc, 32'd5);
    chk("lw_naddr", addr_log.size(), 32'd4);
    for (int i = 0; i < addr_log.size(); i++)
      chk($sformatf("lw_addr%0d", i), addr_log[i], 32'h0001_0000 + i);
    chk("lw_rdata", r_rdata, 32'h1234_5678);
    chk("lw_err", {31'b0, r_err}, 32'd0);
    chk("lw_ready_in_resp", {31'b0, r_ready}, 32'd0);
    @(negedge clk);
    chk("lw_ready_after", {31'b0, bus.req_ready}, 32'd1);
    chk("lw_resp_pulse", {31'b0, bus.resp_valid}, 32'd0);

    // byte/half extension
    do_req(1'b0, 3'b000, 32'h0001_0010, 32'h0);
    chk("lb_rdata", r_rdata, 32'hFFFF_FF80);
    chk("lb_cycles", r_cyc, 32'd2);
    do_req(1'b0, 3'b100, 32'h0001_0010, 32'h0);
    chk("lbu_rdata", r_rdata, 32'h0000_0080);
    do_req(1'b0, 3'b001, 32'h0001_0010, 32'h0);
    chk("lh_rdata", r_rdata, 32'hFFFF_FF80);
    chk("lh_cycles", r_cyc, 32'd3);
    do_req(1'b0, 3'b101, 32'h0001_0010, 32'h0);
    chk("lhu_rdata", r_rdata, 32'h0000_FF80);

    // illegal funct3
    wbase = wlog_a.size();
    do_req(1'b0, 3'b011, 32'h0001_0000, 32'h0);
    chk("ill_ld_cycles", r_cyc, 32'd1);
    chk("ill_ld_err", {31'b0, r_err}, 32'd1);
    chk("ill_ld_rdata", r_rdata, 32'd0);
    do_req(1'b1, 3'b100, 32'h0001_0000, 32'h5555_5555);
    chk("ill_st_cycles", r_cyc, 32'd1);
    chk("ill_st_err", {31'b0, r_err}, 32'd1);
    chk("ill_st_rdata", r_rdata, 32'd0);
    chk("ill_no_writes", wlog_a.size() - wbase, 32'd0);
    @(negedge clk);
    chk("ill_ready_after", {31'b0, bus.req_ready}, 32'd1);

    // misaligned lw
    do_req(1'b0, 3'b010, 32'h0001_0001, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_cycles", r_cyc, 32'd1);
    chk("mis_err", {31'b0, r_err}, 32'd1);
    chk("mis_rdata", r_rdata, 32'd0);
`else
    chk("mis_cycles", r_cyc, 32'd5);
    chk("mis_err", {31'b0, r_err}, 32'd0);
    chk("mis_rdata", r_rdata, 32'h9A12_3456);
    chk("mis_addr_last", addr_log.size() == 4 ? addr_log[3] : 32'hX, 32'h0001_0004);
`endif

    // wrapping halfword load
    do_req(1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("wrap_err", {31'b0, r_err}, 32'd1);
`else
    chk("wrap_rdata", r_rdata, 32'h0000_2211);
    chk("wrap_addr0", addr_log.size() == 2 ? addr_log[0] : 32'hX, 32'hFFFF_FFFF);
    chk("wrap_addr1", addr_log.size() == 2 ? addr_log[1] : 32'hX, 32'h0000_0000);
`endif

    // sh, with req_wdata scrambled after acceptance
    wbase = wlog_a.size();
    do_req(1'b1, 3'b001, 32'h0001_0002, 32'hCAFE_BEEF);
    chk("sh_cycles", r_cyc, 32'd3);
    chk("sh_nwrites", wlog_a.size() - wbase, 32'd2);
    if (wlog_a.size() - wbase == 2) begin
      chk("sh_a0", wlog_a[wbase],     32'h0001_0002);
      chk("sh_d0", {24'b0, wlog_d[wbase]},     32'h0000_00EF);
      chk("sh_a1", wlog_a[wbase + 1], 32'h0001_0003);
      chk("sh_d1", {24'b0, wlog_d[wbase + 1]}, 32'h0000_00BE);
    end
    chk("sh_neighbor", {24'b0, rd(32'h0001_0004)}, 32'h0000_009A);
    chk("sh_err", {31'b0, r_err}, 32'd0);
    chk("sh_rdata", r_rdata, 32'd0);

    // sw / sb then read back
    do_req(1'b1, 3'b010, 32'h0001_0030, 32'h1122_3344);
    chk("sw_cycles", r_cyc, 32'd5);
    do_req(1'b1, 3'b000, 32'h0001_0031, 32'h0000_77AB);
    do_req(1'b0, 3'b100, 32'h0001_0031, 32'h0);
    chk("sb_lbu", r_rdata, 32'h0000_00AB);
    do_req(1'b0, 3'b010, 32'h0001_0030, 32'h0);
    chk("sw_sb_lw", r_rdata, 32'h1122_AB44);

    // reset in the middle of sw
    wbase = wlog_a.size();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h0001_0020;
    bus.req_wdata  = 32'hAABB_CCDD;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready",  {31'b0, bus.req_ready},  32'd1);
    chk("mid_rst_wen",    {31'b0, bus.mem_wen},    32'd0);
    chk("mid_rst_addr",   bus.mem_addr,            32'd0);
    chk("mid_rst_wdata",  {24'b0, bus.mem_wdata},  32'd0);
    chk("mid_rst_rvalid", {31'b0, bus.resp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("mid_rst_nwrites", wlog_a.size() - wbase, 32'd2);
    chk("mid_rst_b0", {24'b0, rd(32'h0001_0020)}, 32'h0000_00DD);
    chk("mid_rst_b1", {24'b0, rd(32'h0001_0021)}, 32'h0000_00CC);
    chk("mid_rst_b2", {24'b0, rd(32'h0001_0022)}, 32'h0000_0000);
    chk("mid_rst_b3", {24'b0, rd(32'h0001_0023)}, 32'h0000_0000);
    rst_n = 1'b1;
    do_req(1'b0, 3'b010, 32'h0001_0020, 32'h0);
    chk("post_rst_cycles", r_cyc, 32'd5);
    chk("post_rst_lw", r_rdata, 32'h0000_CCDD);
    chk("post_rst_err", {31'b0, r_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/lsu_byte_seq.md
# lsu_byte_seq

Load/store sequencer sitting between the core's memory stage and the byte-wide data memory. It accepts one RV32I load or store per handshake, breaks it into single-byte memory accesses at consecutive addresses, drives the byte write strobe and data for stores, and collects bytes for loads. It returns a sign- or zero-extended 32-bit load result or a store completion, with an error flag for illegal requests.

## Interface
- `DATA_WIDTH`, 32, core-side data width.
- `ADDR_WIDTH`, 32, byte address width. All address arithmetic wraps modulo 2^ADDR_WIDTH.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  core presents a request.
- `req_ready`  out  1  high exactly when in IDLE.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I load/store funct3.
- `req_addr`  in  ADDR_WIDTH  byte base address.
- `req_wdata`  in  DATA_WIDTH  store data; low bytes are used.
- `resp_valid`  out  1  one-cycle completion pulse; no back-pressure.
- `resp_rdata`  out  DATA_WIDTH  extended load result; 0 for stores and errors.
- `resp_err`  out  1  qualifies `resp_valid`; request rejected.
- `mem_addr`  out  ADDR_WIDTH  byte address to memory.
- `mem_wen`  out  1  byte write enable, held for the full cycle.
- `mem_wdata`  out  8  byte to write.
- `mem_rdata`  in  8  combinational read byte for `mem_addr`.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE.** `req_ready`=1. When `req_valid` is high, latch `we`, `funct3`, `addr`, `wdata`; clear the byte counter `k` and the result register.
  - Legal request: go to ACCESS.
  - Illegal request: go to RESP with err=1 and no memory activity.
- **Legal funct3.**
  - Loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: 000 sb, 001 sh, 010 sw.
  - Any other value is illegal.
- **Byte count N.** N=1 for funct3[1:0]=00, N=2 for 01, N=4 for 10.
- **ACCESS.** `mem_addr` = base+k.
  - Store: `mem_wen`=1 and `mem_wdata`=wdata[8k+7:8k].
  - Load: `mem_wen`=0; at the rising edge, `mem_rdata` is captured into result byte k.
  - `k` increments each cycle. When k=N-1, go to RESP.
- **RESP.** `resp_valid`=1 for one cycle, then return to IDLE.
- **Load extension.**
  - lb: sign-extend from bit 7.
  - lh: sign-extend from bit 15.
  - lbu, lhu: zero-extend.
  - lw: no extension.
- **Memory port outside ACCESS.** `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0.
- **Input stability.** Request inputs are ignored outside IDLE. Latched store data is immune to changes in `req_wdata` after acceptance.

## Timing
- **Reset values.** While `rst_n` is low, or immediately after it falls:
  - state=IDLE, `req_ready`=1;
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0;
  - `mem_wen`=0, `mem_addr`=0, `mem_wdata`=0.
- **Legal request latency.** Accept edge T → ACCESS in cycles T+1..T+N → `resp_valid` in cycle T+N+1 → `req_ready` high again in T+N+2.
  - Load/store totals: 3 cycles for N=1, 4 for N=2, 6 for N=4.
- **Error latency.** `resp_valid`/`resp_err` in cycle T+1; `req_ready` high again in T+2.
- **No overlap.** No request is accepted in the RESP cycle, so there is at most one outstanding request.
- **Address wrap.** base=0xFFFFFFFF with N=2 accesses 0xFFFFFFFF then 0x00000000.
- **Reset during ACCESS.** Aborts immediately with no `resp_valid`.
  - Store bytes already written remain in memory.
  - No further `mem_wen` is asserted.
- **Memory timing.** Memory read is combinational; a write is committed by the memory within the cycle `mem_wen` is high (either edge).

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined.**
  - Halfword with addr[0]≠0 is illegal.
  - Word with addr[1:0]≠0 is illegal.
  - Illegal requests take the error path: `resp_err`=1 at T+1 and zero memory accesses.
- **`LSU_MISALIGN_TRAP_EN` undefined.** Misaligned accesses are legal and are sequenced byte by byte exactly like aligned ones.

## Test plan
- **lw.** Memory 0x10000..0x10003 = 78 56 34 12; lw at 0x10000 → `mem_addr` 0x10000..0x10003 in 4 consecutive cycles, then `resp_valid`=1 with `resp_rdata`=0x12345678, `resp_err`=0.
- **lb / lbu.** Byte 0x80 at 0x10010.
  - lb → `resp_rdata`=0xFFFFFF80.
  - lbu → `resp_rdata`=0x00000080.
  - lh of 80 FF → 0xFFFFFF80.
  - lhu of 80 FF → 0x0000FF80.
- **sh.** sh `req_wdata`=0xCAFEBEEF at 0x10002 → exactly two `mem_wen` cycles, (0x10002, 0xEF) then (0x10003, 0xBE); memory at 0x10004 is unchanged; `resp_valid` follows on the next cycle.
- **Illegal funct3.** Load with funct3=011 and store with funct3=100 → `resp_valid`=`resp_err`=1 at T+1, `mem_wen` never asserted, `resp_rdata`=0.
- **Misaligned lw at 0x10001.**
  - With `LSU_MISALIGN_TRAP_EN` → error response at T+1, no accesses.
  - Without it → reads 0x10001..0x10004 and returns the assembled word.
- **Reset mid-store.** `rst_n` driven low after the second byte of an sw (value 0xAABBCCDD at 0x10020) → only 0xDD and 0xCC are written, all outputs reach reset values asynchronously, and the next lw after reset completes normally.
